// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder for the CPU MEM stage: six output port
// registers, two debounced switch inputs and a compare/reload timer
// with a maskable, registered interrupt.
module mmio_io_responder #(
  parameter logic [31:0] IO_BASE    = 32'h0000_0080,
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic [3:0]  in_port0,
  input  logic [3:0]  in_port1,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [31:0] out_port3,
  output logic [31:0] out_port4,
  output logic [31:0] out_port5,
  output logic        irq
);

  // Word offsets (addr[6:2]) of the mapped registers
  localparam logic [4:0] OFF_IN0  = 5'd0;
  localparam logic [4:0] OFF_IN1  = 5'd1;
  localparam logic [4:0] OFF_OUT0 = 5'd8;
  localparam logic [4:0] OFF_OUT1 = 5'd9;
  localparam logic [4:0] OFF_OUT2 = 5'd10;
  localparam logic [4:0] OFF_OUT3 = 5'd11;
  localparam logic [4:0] OFF_OUT4 = 5'd12;
  localparam logic [4:0] OFF_OUT5 = 5'd13;
  localparam logic [4:0] OFF_CNT  = 5'd16;
  localparam logic [4:0] OFF_CMP  = 5'd17;
  localparam logic [4:0] OFF_CTRL = 5'd18;

  logic        sel_s;
  logic [4:0]  off_s;
  logic        wr_s;
  logic        rd_s;
  logic        addr_unused_s;
  logic [31:0] rd_data_s;
  logic [31:0] out_r [6];

  logic [31:0] cnt_r;
  logic [31:0] cmp_r;
  logic [31:0] cnt_nxt_s;
  logic        en_r;
  logic        auto_r;
  logic        irq_en_r;
  logic        match_r;
  logic        match_nxt_s;
  logic        irq_en_nxt_s;
  logic        ctrl_wr_s;

  logic [3:0]  in_s       [2];
  logic [3:0]  sync1_r    [2];
  logic [3:0]  sync2_r    [2];
  logic [3:0]  prev_r     [2];
  logic [3:0]  deb_r      [2];
  logic [3:0]  deb_nxt_s  [2];
  logic [15:0] dcnt_r     [2];
  logic [15:0] dcnt_nxt_s [2];

  assign sel_s         = (addr[31:7] == IO_BASE[31:7]);
  assign off_s         = addr[6:2];
  assign wr_s          = we & sel_s;
  assign rd_s          = re & sel_s;
  assign ctrl_wr_s     = wr_s & (off_s == OFF_CTRL);
  assign addr_unused_s = ^addr[1:0];

  assign in_s[0] = in_port0;
  assign in_s[1] = in_port1;

  assign out_port0 = out_r[0];
  assign out_port1 = out_r[1];
  assign out_port2 = out_r[2];
  assign out_port3 = out_r[3];
  assign out_port4 = out_r[4];
  assign out_port5 = out_r[5];

  // Load data multiplexer: pre-write view of every readable register
  always_comb begin
    rd_data_s = 32'd0;
    case (off_s)
      OFF_IN0:  rd_data_s = {28'd0, deb_r[0]};
      OFF_IN1:  rd_data_s = {28'd0, deb_r[1]};
      OFF_OUT0: rd_data_s = out_r[0];
      OFF_OUT1: rd_data_s = out_r[1];
      OFF_OUT2: rd_data_s = out_r[2];
      OFF_OUT3: rd_data_s = out_r[3];
      OFF_OUT4: rd_data_s = out_r[4];
      OFF_OUT5: rd_data_s = out_r[5];
      OFF_CNT:  rd_data_s = cnt_r;
      OFF_CMP:  rd_data_s = cmp_r;
      OFF_CTRL: rd_data_s = {23'd0, match_r, 5'd0, irq_en_r, auto_r, en_r};
      default:  rd_data_s = 32'd0;
    endcase
  end

  // Registered load response; rdata holds until the next in-window load
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata  <= 32'd0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_s;
      if (rd_s) begin
        rdata <= rd_data_s;
      end
    end
  end

  // Output port registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        out_r[i] <= 32'd0;
      end
    end else if (wr_s) begin
      case (off_s)
        OFF_OUT0: out_r[0] <= wdata;
        OFF_OUT1: out_r[1] <= wdata;
        OFF_OUT2: out_r[2] <= wdata;
        OFF_OUT3: out_r[3] <= wdata;
        OFF_OUT4: out_r[4] <= wdata;
        OFF_OUT5: out_r[5] <= wdata;
        default:  ;
      endcase
    end
  end

  // Timer next state: CNT write beats counting; a new match beats W1C
  always_comb begin
    cnt_nxt_s    = cnt_r;
    match_nxt_s  = match_r;
    irq_en_nxt_s = irq_en_r;
    if (wr_s && (off_s == OFF_CNT)) begin
      cnt_nxt_s   = wdata;
      match_nxt_s = (ctrl_wr_s && wdata[8]) ? 1'b0 : match_r;
    end else if (en_r) begin
      if (cnt_r == cmp_r) begin
        match_nxt_s = 1'b1;
        cnt_nxt_s   = auto_r ? 32'd0 : (cnt_r + 32'd1);
      end else begin
        cnt_nxt_s   = cnt_r + 32'd1;
        match_nxt_s = (ctrl_wr_s && wdata[8]) ? 1'b0 : match_r;
      end
    end else begin
      cnt_nxt_s   = cnt_r;
      match_nxt_s = (ctrl_wr_s && wdata[8]) ? 1'b0 : match_r;
    end
    if (ctrl_wr_s) begin
      irq_en_nxt_s = wdata[2];
    end else begin
      irq_en_nxt_s = irq_en_r;
    end
  end

  // Timer, control and interrupt registers; irq tracks MATCH & IRQ_EN as a flop
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r    <= 32'd0;
      cmp_r    <= 32'hFFFF_FFFF;
      en_r     <= 1'b0;
      auto_r   <= 1'b0;
      irq_en_r <= 1'b0;
      match_r  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      match_r  <= match_nxt_s;
      irq_en_r <= irq_en_nxt_s;
      irq      <= match_nxt_s & irq_en_nxt_s;
      if (wr_s && (off_s == OFF_CMP)) begin
        cmp_r <= wdata;
      end
      if (ctrl_wr_s) begin
        en_r   <= wdata[0];
        auto_r <= wdata[1];
      end
    end
  end

  // Debounce next state: count cycles of a stable, changed synchronised value
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_nxt_s[i]  = deb_r[i];
      dcnt_nxt_s[i] = 16'd0;
      if ((sync2_r[i] == deb_r[i]) || (sync2_r[i] != prev_r[i])) begin
        dcnt_nxt_s[i] = 16'd0;
      end else if ((dcnt_r[i] + 16'd1) >= (DEB_CYCLES - 16'd1)) begin
        deb_nxt_s[i]  = sync2_r[i];
        dcnt_nxt_s[i] = 16'd0;
      end else begin
        dcnt_nxt_s[i] = dcnt_r[i] + 16'd1;
      end
    end
  end

  // Two-flop synchronisers, previous-cycle copy and debounce state
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        sync1_r[i] <= 4'd0;
        sync2_r[i] <= 4'd0;
        prev_r[i]  <= 4'd0;
        deb_r[i]   <= 4'd0;
        dcnt_r[i]  <= 16'd0;
      end else begin
        sync1_r[i] <= in_s[i];
        sync2_r[i] <= sync1_r[i];
        prev_r[i]  <= sync2_r[i];
        deb_r[i]   <= deb_nxt_s[i];
        dcnt_r[i]  <= dcnt_nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Randomised + directed bench for mmio_io_responder with a register-map
// reference model and a load-response scoreboard.
module tb_mmio_io_responder;

  localparam int          DEB  = 4;
  localparam logic [31:0] BASE = 32'h0000_0080;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [3:0]  in_port0 = 4'd0;
  logic [3:0]  in_port1 = 4'd0;
  logic [31:0] out_port0, out_port1, out_port2, out_port3, out_port4, out_port5;
  logic        irq;

  always #5 clock = ~clock;

  mmio_io_responder #(.IO_BASE(BASE), .DEB_CYCLES(16'd4)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .rvalid(rvalid), .in_port0(in_port0), .in_port1(in_port1),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
    .out_port3(out_port3), .out_port4(out_port4), .out_port5(out_port5), .irq(irq)
  );

  // Reference model state (value after the most recent clock edge)
  logic [31:0] m_out [6];
  logic [31:0] m_cnt, m_cmp;
  logic        m_en, m_auto, m_irqen, m_match, m_irq;
  logic [3:0]  m_deb [2];
  logic [3:0]  hist [2][8];   // hist[p][k]: input p sampled k+1 edges ago
  logic [31:0] expq [$];
  logic [3:0]  g_in0 = 4'd0, g_in1 = 4'd0;
  bit          chk_en = 1'b0;
  int          total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [6:0] bo);
    if (bo == 7'h00) return {28'd0, m_deb[0]};
    if (bo == 7'h04) return {28'd0, m_deb[1]};
    if (bo >= 7'h20 && bo <= 7'h34) return m_out[(bo - 7'h20) / 7'd4];
    if (bo == 7'h40) return m_cnt;
    if (bo == 7'h44) return m_cmp;
    if (bo == 7'h48) return (m_match ? 32'h100 : 32'h0) | (m_irqen ? 32'h4 : 32'h0)
                          | (m_auto ? 32'h2 : 32'h0) | (m_en ? 32'h1 : 32'h0);
    return 32'd0;
  endfunction

  // What the next clock edge does, in register-map terms
  task automatic model_edge(input bit rst, input bit w, input bit r,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] i0, input logic [3:0] i1);
    bit          in_win, set_match, settled;
    logic [6:0]  bo;
    logic [31:0] n_cnt;
    logic [3:0]  smp [2];
    if (rst) begin
      for (int k = 0; k < 6; k++) m_out[k] = 32'd0;
      m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF;
      {m_en, m_auto, m_irqen, m_match, m_irq} = 5'd0;
      for (int p = 0; p < 2; p++) begin
        m_deb[p] = 4'd0;
        for (int k = 0; k < 8; k++) hist[p][k] = 4'd0;
      end
      return;
    end
    in_win = (a[31:7] == BASE[31:7]);
    bo     = a[6:0] & 7'h7C;
    if (r && in_win) expq.push_back(m_read(bo));
    set_match = 1'b0;
    n_cnt     = m_cnt;
    if (w && in_win && bo == 7'h40) n_cnt = wd;
    else if (m_en) begin
      if (m_cnt == m_cmp) begin
        set_match = 1'b1;
        n_cnt = m_auto ? 32'd0 : m_cnt + 32'd1;
      end else n_cnt = m_cnt + 32'd1;
    end
    m_cnt = n_cnt;
    if (w && in_win) begin
      if (bo >= 7'h20 && bo <= 7'h34) m_out[(bo - 7'h20) / 7'd4] = wd;
      if (bo == 7'h44) m_cmp = wd;
      if (bo == 7'h48) begin
        m_en = wd[0]; m_auto = wd[1]; m_irqen = wd[2];
        if (wd[8]) m_match = 1'b0;
      end
    end
    if (set_match) m_match = 1'b1;
    m_irq = m_match & m_irqen;
    // Debounced value follows the input once it has been steady for DEB
    // synchronised cycles (synchroniser adds two edges of latency).
    smp[0] = i0; smp[1] = i1;
    for (int p = 0; p < 2; p++) begin
      settled = 1'b1;
      for (int k = 2; k <= DEB; k++)
        if (hist[p][k] != hist[p][1]) settled = 1'b0;
      if (settled && hist[p][1] != m_deb[p]) m_deb[p] = hist[p][1];
      for (int k = 7; k > 0; k--) hist[p][k] = hist[p][k-1];
      hist[p][0] = smp[p];
    end
  endtask

  task automatic cyc(input bit rst, input bit w, input bit r,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clock);
    #1;
    reset = rst; we = w; re = r; addr = a; wdata = wd;
    in_port0 = g_in0; in_port1 = g_in1;
    model_edge(rst, w, r, a, wd, g_in0, g_in1);
    if (rst) chk_en = 1'b1;
  endtask

  task automatic wr(input logic [6:0] off, input logic [31:0] v);
    cyc(1'b0, 1'b1, 1'b0, BASE + {25'd0, off}, v);
  endtask

  task automatic rd(input logic [6:0] off);
    cyc(1'b0, 1'b0, 1'b1, BASE + {25'd0, off}, 32'd0);
  endtask

  // Monitor: compare outputs against the model and drain the load scoreboard
  always @(negedge clock) begin
    logic [31:0] op [6];
    if (chk_en) begin
      op = '{out_port0, out_port1, out_port2, out_port3, out_port4, out_port5};
      for (int k = 0; k < 6; k++) check($sformatf("out_port%0d", k), op[k], m_out[k]);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      check("rvalid", {31'd0, rvalid}, {31'd0, expq.size() != 0});
      if (expq.size() != 0) begin
        if (rvalid) check("rdata", rdata, expq.pop_front());
        else void'(expq.pop_front());
      end
    end
  end

  logic [6:0] offs [14];
  initial begin
    logic [31:0] a, v;
    int sel;
    offs = '{7'h00, 7'h04, 7'h20, 7'h24, 7'h28, 7'h2C, 7'h30, 7'h34,
             7'h40, 7'h44, 7'h48, 7'h3C, 7'h08, 7'h7C};
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    // Basic store/load to OUT0
    wr(7'h20, 32'h0000_0005);
    rd(7'h20);
    // Debounce: step to A, then a 3-cycle glitch to 3
    g_in0 = 4'hA; g_in1 = 4'h5;
    repeat (9) rd(7'h00);
    g_in0 = 4'h3;
    repeat (3) rd(7'h00);
    g_in0 = 4'hA;
    repeat (8) rd(7'h00);
    rd(7'h04);
    // Timer with auto-reload and interrupt, then W1C
    wr(7'h44, 32'd5); wr(7'h40, 32'd0); wr(7'h48, 32'h7);
    repeat (14) rd(7'h40);
    wr(7'h48, 32'h100);
    rd(7'h48);
    // Wrap-around without reload, W1C on the match edge
    wr(7'h48, 32'h0); wr(7'h44, 32'd3); wr(7'h40, 32'hFFFF_FFFE); wr(7'h48, 32'h1);
    repeat (3) rd(7'h40);
    for (int k = 0; k < 10 && m_cnt != m_cmp; k++) rd(7'h40);
    wr(7'h48, 32'h101);
    rd(7'h48); rd(7'h40);
    // Decode boundaries and same-cycle store+load
    wr(7'h3C, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'd0);
    rd(7'h3C);
    wr(7'h28, 32'h22);
    cyc(1'b0, 1'b1, 1'b1, BASE + 32'h28, 32'h33);
    rd(7'h28);
    // Reset mid-count with a load pending
    wr(7'h48, 32'h1);
    repeat (3) rd(7'h40);
    cyc(1'b1, 1'b0, 1'b1, BASE + 32'h40, 32'd0);
    rd(7'h44); rd(7'h40);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) g_in0 = 4'($urandom);
      if ($urandom_range(0, 19) == 0) g_in1 = 4'($urandom);
      sel = $urandom_range(0, 13);
      a   = BASE + {25'd0, offs[sel]} + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      v = $urandom;
      if (offs[sel] == 7'h40 || offs[sel] == 7'h44) v = 32'($urandom_range(0, 12));
      if (offs[sel] == 7'h48 && $urandom_range(0, 1) == 1) v = v | 32'h1;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, a, v);
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("queue_drain", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_io_responder.md
Name: mmio_io_responder

Overview:
- Memory-mapped I/O responder on the data-memory side of the pipelined CPU's MEM stage; it answers the loads and stores the CPU issues to the I/O window.
- Owns the six 32-bit output port registers, which also feed the seven-segment decoders.
- Synchronises and debounces the two 4-bit switch inputs.
- Provides a 32-bit compare/reload timer with a maskable interrupt flag.
- At integration, clock is driven by the CPU's mem_clock.

Parameters:
- IO_BASE, 32'h0000_0080, base of the 128-byte I/O window; decode compares addr[31:7] with IO_BASE[31:7].
- DEB_CYCLES, 16'd50000, number of consecutive stable synchronised cycles needed before a debounced input updates; legal range 1..65535.

Ports:
- clock  in  1  sole clock.
- reset  in  1  reset; synchronous, active-high.
- addr  in  32  byte address from MEM stage; addr[1:0] ignored.
- wdata  in  32  store data.
- we  in  1  store strobe, one cycle per store.
- re  in  1  load strobe, one cycle per load.
- rdata  out  32  registered load data.
- rvalid  out  1  one-cycle pulse, rdata valid.
- in_port0  in  4  asynchronous switch input 0.
- in_port1  in  4  asynchronous switch input 1.
- out_port0..out_port5  out  32 each  output port registers.
- irq  out  1  timer interrupt request, level.

Behaviour:
- Decode: sel = (addr[31:7] == IO_BASE[31:7]); off = addr[6:2]. A we or re with sel=0 has no effect and gives no rvalid.
- Address map (byte offsets within the window):
  - 0x00 IN0: RO, {28'b0, deb0}.
  - 0x04 IN1: RO, {28'b0, deb1}.
  - 0x20–0x34 OUT0–OUT5: RW; a write loads wdata, a read returns the current value.
  - 0x40 CNT: RW timer count.
  - 0x44 CMP: RW compare value.
  - 0x48 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN (all RW); bit8 MATCH, which reads current state and is cleared by writing 1 (W1C); all other bits read 0 and ignore writes.
  - Unmapped offsets read 0; writes to them are ignored.
- Write timing: a write takes effect on the clock edge that samples we=1 and is visible on out_port* in the following cycle.
- Read timing:
  - A re sampled at edge N drives rdata/rvalid after edge N.
  - rdata holds its value until the next in-window read.
  - rvalid is high for exactly one cycle.
- we and re in the same cycle: both are performed; the read returns the pre-write value.
- Input path: two-flop synchroniser per bit, giving syncX. Per port X, a counter cntX (16 bit):
  - If syncX == debX or syncX != syncX of the previous cycle, cntX <= 0.
  - Otherwise cntX increments; when it reaches DEB_CYCLES-1 on the same edge, debX <= syncX and cntX <= 0.
  - Net effect: debX changes only after syncX has differed from debX and stayed constant for DEB_CYCLES cycles.
- Timer, evaluated each edge in this priority order:
  1. A CNT write loads wdata; no increment that cycle.
  2. Else, if EN: if CNT == CMP, set MATCH and load CNT with 0 when AUTO_RELOAD=1, else CNT+1 (mod 2^32). If CNT != CMP, CNT+1, wrapping FFFF_FFFF→0.
  3. Else CNT holds.
- MATCH: a W1C write and a new match on the same edge leave MATCH=1 (set wins).
- irq = MATCH & IRQ_EN, registered (it is a flop output).
- Reset (synchronous, active-high):
  - out_port0–5 = 0, rdata = 0, rvalid = 0, irq = 0.
  - CNT = 0, CMP = 32'hFFFF_FFFF, CTRL = 0.
  - Synchronisers, deb0, deb1 and counters = 0.
  - Reset asserted mid-operation overrides any same-cycle we/re; pending reads are dropped with no rvalid.

Test Plan:
- Reset, then store 0x0000_0005 to 0x0000_00A0 and load 0x0000_00A0 → out_port0 = 5 one cycle after we; rvalid pulses once with rdata = 5; out_port1–5 remain 0.
- DEB_CYCLES=4: in_port0 0→4'hA and held → IN0 reads 0 until 2 (sync) + 4 cycles have elapsed, then reads 0x0000_000A; a 3-cycle glitch to 4'h3 never appears on IN0.
- Timer: CMP=5, CTRL=0x7, starting from CNT=0 → MATCH and irq rise after CNT reaches 5; CNT returns to 0 and the cycle repeats every 6 cycles; W1C of 0x100 on CTRL clears irq the next cycle.
- Wrap: CNT=0xFFFF_FFFE, CMP=3, AUTO_RELOAD=0, EN=1 → CNT sequence FFFF_FFFF, 0, 1, 2, 3 with MATCH set at 3; W1C on the same edge as a match leaves MATCH=1.
- Decode boundaries: store to 0x0000_0100 (outside window) and to offset 0x3C (unmapped) → no register change, loads give no rvalid / 0 respectively; same-cycle we+re to OUT2 returns the old value.
- Assert reset for one cycle mid-timer-count with re high → all outputs return to reset values, no rvalid, CMP reads back FFFF_FFFF.
